// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display image load strobe/data and digit scan outputs
interface seg_scan_ctrl_if;
    logic        i_load;
    logic [31:0] i_digits_in;
    logic [7:0]  i_blank_mask_in;
    logic [7:0]  i_blink_mask_in;
    logic [7:0]  o_dig_sel;
    logic [6:0]  o_seg;
    logic [2:0]  o_scan_idx;
    logic        o_frame_done;
    logic        o_pending;

    modport master (
        output i_load, i_digits_in, i_blank_mask_in, i_blink_mask_in,
        input  o_dig_sel, o_seg, o_scan_idx, o_frame_done, o_pending
    );

    modport slave (
        input  i_load, i_digits_in, i_blank_mask_in, i_blink_mask_in,
        output o_dig_sel, o_seg, o_scan_idx, o_frame_done, o_pending
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan with frame-synchronous double-buffered image
module seg_scan_ctrl #(
    parameter int DIV_MAX      = 24999,
    parameter int NUM_DIGITS   = 7,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input logic            clk,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);
    logic [31:0] r_cnt;
    logic [31:0] r_frm;
    logic [2:0]  r_idx;
    logic        r_fd;
    logic        r_pending;
    logic        r_phase;
    logic [47:0] r_shadow;
    logic [47:0] r_active;
    logic [7:0]  r_dig_sel;
    logic [6:0]  r_seg;
    logic        w_tick;
    logic        w_wrap;
    logic        w_dark;
    logic [47:0] w_in;
    logic [31:0] w_dig;
    logic [7:0]  w_blank;
    logic [7:0]  w_blink;
    logic [3:0]  w_nib;
    logic [6:0]  w_pat;

    // image word layout: {blink mask, blank mask, digit nibbles}
    assign w_in    = {bus.i_blink_mask_in, bus.i_blank_mask_in, bus.i_digits_in};
    assign w_dig   = r_active[31:0];
    assign w_blank = r_active[39:32];
    assign w_blink = r_active[47:40];
    assign w_tick  = r_cnt == 32'(DIV_MAX);
    assign w_wrap  = w_tick && r_idx == 3'(NUM_DIGITS - 1);
    assign w_nib   = w_dig[{r_idx, 2'b00} +: 4];
    assign w_dark  = r_cnt < 32'(GUARD) || w_blank[r_idx] || (w_blink[r_idx] && r_phase);

    always_comb begin
        case (w_nib)
            4'h0: w_pat = 7'h3F;
            4'h1: w_pat = 7'h06;
            4'h2: w_pat = 7'h5B;
            4'h3: w_pat = 7'h4F;
            4'h4: w_pat = 7'h66;
            4'h5: w_pat = 7'h6D;
            4'h6: w_pat = 7'h7D;
            4'h7: w_pat = 7'h07;
            4'h8: w_pat = 7'h7F;
            4'h9: w_pat = 7'h6F;
            4'hA: w_pat = 7'h77;
            4'hB: w_pat = 7'h7C;
            4'hC: w_pat = 7'h39;
            4'hD: w_pat = 7'h5E;
            4'hE: w_pat = 7'h79;
            default: w_pat = 7'h71;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_fd  <= 1'b0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 32'd1;
            if (w_tick)
                r_idx <= w_wrap ? '0 : r_idx + 3'd1;
            r_fd <= w_wrap;
        end
    end

    // a load landing on the wrap edge bypasses the shadow straight into the new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (bus.i_load)
                r_shadow <= w_in;
            if (w_wrap) begin
                if (bus.i_load)
                    r_active <= w_in;
                else if (r_pending)
                    r_active <= r_shadow;
                r_pending <= 1'b0;
            end else if (bus.i_load) begin
                r_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frm   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_frm <= r_frm == 32'(BLINK_FRAMES - 1) ? '0 : r_frm + 32'd1;
            if (r_frm == 32'(BLINK_FRAMES - 1))
                r_phase <= ~r_phase;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig_sel <= 8'hFF;
            r_seg     <= 7'h7F;
        end else begin
            r_dig_sel <= w_dark ? 8'hFF : ~(8'd1 << r_idx);
            r_seg     <= w_dark ? 7'h7F : ~w_pat;
        end
    end

    assign bus.o_dig_sel    = r_dig_sel;
    assign bus.o_seg        = r_seg;
    assign bus.o_scan_idx   = r_idx;
    assign bus.o_frame_done = r_fd;
    assign bus.o_pending    = r_pending;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: vector table, corner sequences and random loads against an arithmetic frame model
module tb_seg_scan_ctrl;
    localparam int DM = 10, ND = 7, GD = 2, BF = 2, FR = DM * ND;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  blank;
        int          slot;
        logic [7:0]  dsel;
        logic [6:0]  seg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int unsigned ecnt = 0;
    int unsigned ld_e[$];
    logic [47:0] ld_v[$];
    logic [6:0]  pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0]  bexp [6] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'hFE, 8'hFE};
    vec_t        vecs [6];

    seg_scan_ctrl_if u_if();
    seg_scan_ctrl_if u_if1();

    seg_scan_ctrl #(.DIV_MAX(9), .NUM_DIGITS(7), .GUARD(2), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .bus(u_if)
    );
    seg_scan_ctrl #(.DIV_MAX(3), .NUM_DIGITS(1), .GUARD(0), .BLINK_FRAMES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(u_if1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h want %h", name, ecnt, act, exp);
        end
    endtask

    // image in effect in state s: newest load taken at or before the edge that began s's frame
    function automatic logic [47:0] img_at(input int unsigned s);
        logic [47:0] v;
        v = '0;
        foreach (ld_e[i])
            if (ld_e[i] <= (s / FR) * FR)
                v = ld_v[i];
        return v;
    endfunction

    task automatic check_all();
        int unsigned n, s;
        int          k;
        logic [47:0] img;
        logic        dark, pend, efd;
        logic [7:0]  ed;
        logic [6:0]  es;
        logic [2:0]  eidx;
        n    = ecnt;
        s    = (n == 0) ? 0 : n - 1;
        k    = int'((s / DM) % ND);
        img  = img_at(s);
        dark = (n == 0) || (s % DM) < GD || img[32 + k] || (img[40 + k] && ((s / FR) / BF) % 2 == 1);
        pend = 1'b0;
        foreach (ld_e[i])
            if (ld_e[i] > (n / FR) * FR)
                pend = 1'b1;
        if (dark) begin
            ed = 8'hFF;
            es = 7'h7F;
        end else begin
            ed = ~(8'd1 << k);
            es = ~pat[img[4 * k +: 4]];
        end
        eidx = 3'((n / DM) % ND);
        efd  = (n % FR == 0) && n != 0;
        chk("dig_sel", u_if.o_dig_sel, ed);
        chk("seg", u_if.o_seg, es);
        chk("scan_idx", u_if.o_scan_idx, eidx);
        chk("frame_done", u_if.o_frame_done, efd);
        chk("pending", u_if.o_pending, pend);
        chk("n1_dig_sel", u_if1.o_dig_sel, n == 0 ? 8'hFF : 8'hFE);
        chk("n1_seg", u_if1.o_seg, n == 0 ? 7'h7F : 7'h40);
        chk("n1_scan_idx", u_if1.o_scan_idx, 0);
        chk("n1_frame_done", u_if1.o_frame_done, n % 4 == 0 && n != 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) begin
            ecnt++;
            if (u_if.i_load) begin
                ld_e.push_back(ecnt);
                ld_v.push_back({u_if.i_blink_mask_in, u_if.i_blank_mask_in, u_if.i_digits_in});
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic go(input int unsigned n);
        for (int i = 0; i < 20000 && ecnt < n; i++)
            cyc();
        if (ecnt < n)
            chk("go_bound", ecnt, n);
    endtask

    task automatic load_at(input int unsigned e, input logic [31:0] d, input logic [7:0] bl,
                           input logic [7:0] bk);
        go(e - 1);
        u_if.i_load          = 1'b1;
        u_if.i_digits_in     = d;
        u_if.i_blank_mask_in = bl;
        u_if.i_blink_mask_in = bk;
        cyc();
        u_if.i_load = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_dig_sel"}, u_if.o_dig_sel, 8'hFF);
        chk({tag, "_seg"}, u_if.o_seg, 7'h7F);
        chk({tag, "_scan_idx"}, u_if.o_scan_idx, 0);
        chk({tag, "_pending"}, u_if.o_pending, 0);
        chk({tag, "_frame_done"}, u_if.o_frame_done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f;
        int lit, fdc, b7;
        vecs[0] = '{32'h06543210, 8'h00, 1, 8'hFD, 7'h79};
        vecs[1] = '{32'h06543210, 8'h00, 6, 8'hBF, 7'h02};
        vecs[2] = '{32'h00000A00, 8'h00, 2, 8'hFB, 7'h08};
        vecs[3] = '{32'h00000900, 8'h04, 2, 8'hFF, 7'h7F};
        vecs[4] = '{32'h0000C0E0, 8'h00, 1, 8'hFD, 7'h06};
        vecs[5] = '{32'h000B0000, 8'h00, 4, 8'hEF, 7'h03};
        {u_if.i_load, u_if.i_digits_in, u_if.i_blank_mask_in, u_if.i_blink_mask_in} = '0;
        {u_if1.i_load, u_if1.i_digits_in, u_if1.i_blank_mask_in, u_if1.i_blink_mask_in} = '0;
        #1 rst = 1'b1;
        cyc();
        cyc();
        chk_reset_outs("rst");
        rst = 1'b0;
        // digit 0 appears only once the prescaler passes the guard, one clk later
        cyc();
        chk("guard_e1", u_if.o_dig_sel, 8'hFF);
        cyc();
        chk("guard_e2", u_if.o_dig_sel, 8'hFF);
        cyc();
        chk("guard_e3_dig_sel", u_if.o_dig_sel, 8'hFE);
        chk("guard_e3_seg", u_if.o_seg, 7'h40);
        lit = 0;
        fdc = 0;
        b7  = 0;
        repeat (140) begin
            cyc();
            lit += int'(u_if.o_dig_sel != 8'hFF);
            fdc += int'(u_if.o_frame_done);
            b7  += int'(!u_if.o_dig_sel[7]);
        end
        chk("lit_clks", lit, 112);
        chk("frame_done_cnt", fdc, 2);
        chk("dig7_low", b7, 0);
        foreach (vecs[i]) begin
            f = ecnt / FR + 1;
            load_at(f * FR + 30, vecs[i].dig, vecs[i].blank, 8'h00);
            chk("tbl_pending_set", u_if.o_pending, 1);
            go((f + 1) * FR + vecs[i].slot * DM + 6);
            chk("tbl_dig_sel", u_if.o_dig_sel, vecs[i].dsel);
            chk("tbl_seg", u_if.o_seg, vecs[i].seg);
            chk("tbl_pending_clr", u_if.o_pending, 0);
        end
        f = ecnt / FR + 1;
        load_at(f * FR, 32'h8, 8'h00, 8'h00);
        chk("sim_pending", u_if.o_pending, 0);
        go(f * FR + 6);
        chk("sim_dig_sel", u_if.o_dig_sel, 8'hFE);
        chk("sim_seg", u_if.o_seg, 7'h00);
        f = ecnt / FR + 1;
        load_at(f * FR + 20, 32'h3, 8'h00, 8'h00);
        load_at(f * FR + 40, 32'h5, 8'h00, 8'h00);
        go((f + 1) * FR + 6);
        chk("last_dig_sel", u_if.o_dig_sel, 8'hFE);
        chk("last_seg", u_if.o_seg, 7'h12);
        repeat (1400) begin
            if ($urandom_range(39, 0) == 0) begin
                u_if.i_load          = 1'b1;
                u_if.i_digits_in     = $urandom;
                u_if.i_blank_mask_in = 8'($urandom & $urandom & $urandom);
                u_if.i_blink_mask_in = 8'($urandom & $urandom);
            end
            cyc();
            u_if.i_load = 1'b0;
        end
        f = ecnt / FR + 1;
        load_at(f * FR, 32'h0, 8'h00, 8'h00);
        load_at(f * FR + 30, 32'h0, 8'h00, 8'h00);
        go(f * FR + 36);
        chk("pre_rst_dig_sel", u_if.o_dig_sel, 8'hF7);
        chk("pre_rst_pending", u_if.o_pending, 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outs("async_rst");
        ld_e.delete();
        ld_v.delete();
        ecnt = 0;
        cyc();
        rst = 1'b0;
        load_at(1, 32'h0, 8'h00, 8'h01);
        for (int w = 0; w < 6; w++) begin
            go(w * FR + 6);
            chk("blink_dig_sel", u_if.o_dig_sel, bexp[w]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
